switch_debounce_events: RTL

SWITCH_DEBOUNCE_EVENTS -- requirements
Module: switch_debounce_events

---
 rtl/switch_debounce_events.sv | 123 ++++++++++++
 1 files changed

// File: rtl/switch_debounce_events.sv
// Switch conditioner: 2-flop sync, debounce, and press/release/long-press/held events.
// Latency DEBOUNCE_LIMIT+1 edges from first sampled level to o_Switch; event pulses are registered; no backpressure.
module switch_debounce_events #(
    parameter int DEBOUNCE_LIMIT   = 250000,
    parameter int LONG_PRESS_LIMIT = 25000000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Press,
    output logic o_Release,
    output logic o_Long_Press,
    output logic o_Held
);

    localparam int DW = $clog2(DEBOUNCE_LIMIT);
    localparam int HW = $clog2(LONG_PRESS_LIMIT);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_LIMIT - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_LIMIT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_t;

    logic          r_Sync1;
    logic          r_Sync2;
    logic [DW-1:0] deb_cnt;
    logic [HW-1:0] hold_cnt;
    state_t        state;
    state_t        state_nxt;
    logic          deb_flip;
    logic          press_nxt;
    logic          release_nxt;
    logic          long_nxt;
    logic          hold_clr;
    logic          hold_inc;

    // A flip needs DEBOUNCE_LIMIT consecutive edges of disagreement.
    assign deb_flip = (r_Sync2 != o_Switch) && (deb_cnt == DEB_MAX);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Sync1  <= 1'b0;
            r_Sync2  <= 1'b0;
            deb_cnt  <= '0;
            o_Switch <= 1'b0;
        end else begin
            r_Sync1 <= i_Switch;
            r_Sync2 <= r_Sync1;
            if (r_Sync2 == o_Switch) begin
                deb_cnt <= '0;
            end else if (deb_flip) begin
                deb_cnt  <= '0;
                o_Switch <= ~o_Switch;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        long_nxt    = 1'b0;
        hold_clr    = 1'b0;
        hold_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (deb_flip && !o_Switch) begin
                    state_nxt = PRESSED;
                    press_nxt = 1'b1;
                    hold_clr  = 1'b1;
                end
            end
            PRESSED: begin
                // Release takes priority over reaching the long-press threshold.
                if (deb_flip) begin
                    state_nxt   = IDLE;
                    release_nxt = 1'b1;
                end else if (hold_cnt == HOLD_MAX) begin
                    state_nxt = HELD;
                    long_nxt  = 1'b1;
                end else begin
                    hold_inc = 1'b1;
                end
            end
            HELD: begin
                if (deb_flip) begin
                    state_nxt   = IDLE;
                    release_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            o_Press      <= 1'b0;
            o_Release    <= 1'b0;
            o_Long_Press <= 1'b0;
            o_Held       <= 1'b0;
        end else begin
            state        <= state_nxt;
            o_Press      <= press_nxt;
            o_Release    <= release_nxt;
            o_Long_Press <= long_nxt;
            o_Held       <= (state_nxt == HELD);
            if (hold_clr) begin
                hold_cnt <= '0;
            end else if (hold_inc) begin
                hold_cnt <= hold_cnt + HW'(1);
            end
        end
    end

endmodule
